if_fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and selects the next PC: sequential or execute-stage redirect (branch/jal/jalr).
- Drives the combinational instruction-memory address and captures the returned word into the IF/ID pipeline register.
- Honours stall and flush from the hazard unit and keeps a fetch counter for performance/debug.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_fetch_stage_if.sv | 13 +
 rtl/if_fetch_stage_if_id_reg.sv | 27 ++
 rtl/if_fetch_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: default widths, the bubble instruction and the
// IF/ID record that the fetch stage produces and the decode stage consumes.
package riscv_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned INST_WIDTH_DEF = 32;

   // addi x0, x0, 0
   localparam logic [INST_WIDTH_DEF-1:0] NOP_INST_DEF = 32'h0000_0013;

   typedef struct packed {
      logic [INST_WIDTH_DEF-1:0] instr;
      logic [ADDR_WIDTH_DEF-1:0] pc;
      logic [ADDR_WIDTH_DEF-1:0] pc_plus1;
      logic                      valid;
   } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus: word address out, instruction back in the same cycle.
interface if_fetch_stage_if
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned INST_WIDTH = INST_WIDTH_DEF
);
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [INST_WIDTH-1:0] imem_instr;

   modport master (output imem_addr, input imem_instr);
   modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats capture; resets to a bubble.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [INST_WIDTH_DEF-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   stall,
   input  if_id_t d,
   output if_id_t q
);

   localparam if_id_t BUBBLE = '{instr: NOP_INST, pc: '0, pc_plus1: '0, valid: 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= BUBBLE;
      end else if (flush) begin
         q <= BUBBLE;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects sequential vs redirect next PC,
// and fills the IF/ID register from a zero-latency instruction memory.
module if_fetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned           INST_WIDTH = INST_WIDTH_DEF,
   parameter int unsigned           IMEM_DEPTH = 1024,
   parameter int unsigned           RESET_PC   = 0,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = NOP_INST_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_f,
   input  logic                  stall_d,
   input  logic                  flush_d,
   input  logic                  pc_src_e,
   input  logic [ADDR_WIDTH-1:0] pc_target_e,
   if_fetch_stage_if.master      imem,
   output logic [INST_WIDTH-1:0] instr_d,
   output logic [ADDR_WIDTH-1:0] pc_d,
   output logic [ADDR_WIDTH-1:0] pc_plus1_d,
   output logic                  valid_d,
   output logic [31:0]           fetch_count
);

   // One extra bit so a depth of 2^ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(IMEM_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_f;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] pc_plus1_f;
   logic                  in_range;
   if_id_t                cap;
   if_id_t                id_q;

   assign pc_plus1_f     = pc_f + ADDR_WIDTH'(1);
   assign in_range       = ({1'b0, pc_f} < DEPTH_LIM);
   assign imem.imem_addr = pc_f;

   // Redirect wins over stall_f: the branch in execute is older than the stalled fetch.
   always_comb begin
      pc_next = pc_plus1_f;
      if (pc_src_e) begin
         pc_next = pc_target_e;
      end else if (stall_f) begin
         pc_next = pc_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f <= ADDR_WIDTH'(RESET_PC);
      end else begin
         pc_f <= pc_next;
      end
   end

   always_comb begin
      cap          = '0;
      cap.instr    = in_range ? imem.imem_instr : NOP_INST;
      cap.pc       = pc_f;
      cap.pc_plus1 = pc_plus1_f;
      cap.valid    = in_range;
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_d),
      .stall (stall_d),
      .d     (cap),
      .q     (id_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (!flush_d && !stall_d && in_range) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

   assign instr_d    = id_q.instr;
   assign pc_d       = id_q.pc;
   assign pc_plus1_d = id_q.pc_plus1;
   assign valid_d    = id_q.valid;

endmodule
